// File: rtl/jtag_host_driver_if.sv
// Command/response port between the test sequencer (master) and the JTAG host driver (slave).
// Commands and responses each use their own valid/ready pair.
interface jtag_host_driver_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_host_driver.sv
// JTAG initiator: turns RESET / IR_SCAN / DR_SCAN / IDLE commands into TCK/TMS/TDI activity,
// captures TDO, and mirrors the target TAP state.
module jtag_host_driver #(
  parameter int TCK_HALF = 2,
  parameter int MAX_LEN  = 32,
  parameter int LEN_W    = 6
) (
  input  logic              clk,
  input  logic              TRST_n,
  jtag_host_driver_if.slave cmd_if,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic [3:0]        tap_state
);
  localparam int SEQ_W  = MAX_LEN + 8;
  localparam int CNT_W  = $clog2(SEQ_W + 1);
  localparam int HALF_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  localparam logic [3:0] TAP_TLR       = 4'd0;
  localparam logic [3:0] TAP_RTI       = 4'd1;
  localparam logic [3:0] TAP_SEL_DR    = 4'd2;
  localparam logic [3:0] TAP_CAP_DR    = 4'd3;
  localparam logic [3:0] TAP_SHIFT_DR  = 4'd4;
  localparam logic [3:0] TAP_EXIT1_DR  = 4'd5;
  localparam logic [3:0] TAP_PAUSE_DR  = 4'd6;
  localparam logic [3:0] TAP_EXIT2_DR  = 4'd7;
  localparam logic [3:0] TAP_UPD_DR    = 4'd8;
  localparam logic [3:0] TAP_SEL_IR    = 4'd9;
  localparam logic [3:0] TAP_CAP_IR    = 4'd10;
  localparam logic [3:0] TAP_SHIFT_IR  = 4'd11;
  localparam logic [3:0] TAP_EXIT1_IR  = 4'd12;
  localparam logic [3:0] TAP_PAUSE_IR  = 4'd13;
  localparam logic [3:0] TAP_EXIT2_IR  = 4'd14;
  localparam logic [3:0] TAP_UPD_IR    = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLK_LO = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic logic [3:0] tap_next(input logic [3:0] cur, input logic tms);
    logic [3:0] nxt;
    case (cur)
      TAP_TLR:      nxt = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   nxt = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

  state_e             state_r;
  logic               cmd_ready_r;
  logic               rsp_valid_r;
  logic               rsp_err_r;
  logic [MAX_LEN-1:0] rsp_data_r;
  logic               tck_r;
  logic               tms_r;
  logic               tdi_r;
  logic [3:0]         tap_state_r;
  logic [1:0]         op_r;
  logic [LEN_W-1:0]   len_r;
  logic [MAX_LEN-1:0] shift_r;
  logic [MAX_LEN-1:0] cap_r;
  logic [MAX_LEN-1:0] cap_mask_r;
  logic [SEQ_W-1:0]   seq_r;
  logic [CNT_W-1:0]   bits_left_r;
  logic [HALF_W-1:0]  half_cnt_r;

  logic               err_s;
  logic               scan_op_s;
  logic               shifting_s;
  logic               half_last_s;
  logic [SEQ_W-1:0]   seq_s;
  logic [SEQ_W-1:0]   hdr_s;
  logic [CNT_W-1:0]   total_s;
  logic [CNT_W-1:0]   pre_s;
  logic [CNT_W-1:0]   hdr_len_s;
  logic [CNT_W-1:0]   len_ext_s;

  // Build the LSB-first TMS sequence and bit count for the latched command.
  always_comb begin
    scan_op_s   = (op_r == OP_IR) || (op_r == OP_DR);
    shifting_s  = scan_op_s && ((tap_state_r == TAP_SHIFT_DR) || (tap_state_r == TAP_SHIFT_IR));
    half_last_s = (half_cnt_r == HALF_W'(TCK_HALF - 1));
    len_ext_s   = CNT_W'(len_r);
    if (tap_state_r == TAP_TLR) begin
      pre_s = CNT_W'(1'b1);
    end else begin
      pre_s = '0;
    end
    if (op_r == OP_IR) begin
      hdr_s     = SEQ_W'(4'b0011);
      hdr_len_s = CNT_W'(3'd4);
    end else begin
      hdr_s     = SEQ_W'(4'b0001);
      hdr_len_s = CNT_W'(3'd3);
    end
    err_s   = 1'b0;
    seq_s   = '0;
    total_s = '0;
    case (op_r)
      OP_RESET: begin
        seq_s   = SEQ_W'(6'b011111);
        total_s = CNT_W'(3'd6);
      end
      OP_IR, OP_DR: begin
        if ((len_r == '0) || (len_r > LEN_W'(MAX_LEN))) begin
          err_s = 1'b1;
        end else begin
          // Header after the optional TLR->RTI bit, then exit on the last shift bit, Update, RTI.
          seq_s   = (hdr_s << pre_s)
                  | (SEQ_W'(3'b011) << (pre_s + hdr_len_s + len_ext_s - CNT_W'(1'b1)));
          total_s = pre_s + hdr_len_s + len_ext_s + CNT_W'(2'd2);
        end
      end
      OP_IDLE: begin
        if ((len_r == '0) || (len_r > LEN_W'(MAX_LEN))) begin
          err_s = 1'b1;
        end else begin
          total_s = pre_s + len_ext_s;
        end
      end
      default: err_s = 1'b1;
    endcase
  end

  // Controller: accept, generate TCK bits, sample TDO on TCK rise, hold response.
  always_ff @(posedge clk or negedge TRST_n) begin
    if (!TRST_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= '0;
      tck_r       <= 1'b0;
      tms_r       <= 1'b1;
      tdi_r       <= 1'b0;
      tap_state_r <= TAP_TLR;
      op_r        <= OP_RESET;
      len_r       <= '0;
      shift_r     <= '0;
      cap_r       <= '0;
      cap_mask_r  <= '0;
      seq_r       <= '0;
      bits_left_r <= '0;
      half_cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_ready_r && cmd_if.cmd_valid) begin
            cmd_ready_r <= 1'b0;
            op_r        <= cmd_if.cmd_op;
            len_r       <= cmd_if.cmd_len;
            shift_r     <= cmd_if.cmd_data;
            state_r     <= ST_LOAD;
          end else if (!rsp_valid_r) begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          cap_r      <= '0;
          cap_mask_r <= {{(MAX_LEN-1){1'b0}}, 1'b1};
          rsp_data_r <= '0;
          half_cnt_r <= '0;
          if (err_s) begin
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            rsp_err_r   <= 1'b0;
            seq_r       <= seq_s;
            bits_left_r <= total_s;
            tms_r       <= seq_s[0];
            tdi_r       <= shifting_s ? shift_r[0] : 1'b0;
            state_r     <= ST_CLK_LO;
          end
        end
        ST_CLK_LO: begin
          if (half_last_s) begin
            half_cnt_r  <= '0;
            tck_r       <= 1'b1;
            tap_state_r <= tap_next(tap_state_r, tms_r);
            if (shifting_s) begin
              if (TDO) begin
                cap_r <= cap_r | cap_mask_r;
              end
              cap_mask_r <= {cap_mask_r[MAX_LEN-2:0], 1'b0};
              shift_r    <= {1'b0, shift_r[MAX_LEN-1:1]};
            end
            state_r <= ST_CLK_HI;
          end else begin
            half_cnt_r <= half_cnt_r + HALF_W'(1'b1);
          end
        end
        ST_CLK_HI: begin
          if (half_last_s) begin
            half_cnt_r  <= '0;
            tck_r       <= 1'b0;
            bits_left_r <= bits_left_r - CNT_W'(1'b1);
            seq_r       <= {1'b0, seq_r[SEQ_W-1:1]};
            if (bits_left_r == CNT_W'(1'b1)) begin
              tdi_r   <= 1'b0;
              state_r <= ST_RESP;
            end else begin
              // tap_state_r already holds the post-rise state, so it decides the next TDI.
              tms_r   <= seq_r[1];
              tdi_r   <= shifting_s ? shift_r[0] : 1'b0;
              state_r <= ST_CLK_LO;
            end
          end else begin
            half_cnt_r <= half_cnt_r + HALF_W'(1'b1);
          end
        end
        ST_RESP: begin
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= cap_r;
          end else if (cmd_if.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_if.cmd_ready = cmd_ready_r;
  assign cmd_if.rsp_valid = rsp_valid_r;
  assign cmd_if.rsp_data  = rsp_data_r;
  assign cmd_if.rsp_err   = rsp_err_r;
  assign TCK              = tck_r;
  assign TMS              = tms_r;
  assign TDI              = tdi_r;
  assign tap_state        = tap_state_r;
endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver: table of commands with hand-computed results, plus
// sequences for reset, mid-scan TRST, response back-pressure and the TLR prefix.
module tb_jtag_host_driver;
  localparam int TCK_HALF = 2;
  localparam int MAX_LEN  = 32;
  localparam int LEN_W    = 6;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic        tdo1;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_tcks;
    logic [3:0]  exp_state;
  } vec_t;

  logic       clk;
  logic       TRST_n;
  logic       TCK;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       tdo_force;
  logic [3:0] tap_state;
  logic [3:0] m_state;
  int         n_vec;
  int         n_bad;
  int         rise_cnt = 0;
  int         high_cnt = 0;
  logic       tms_log   [256];
  logic [3:0] trace_log [256];

  jtag_host_driver_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) ifc ();

  jtag_host_driver #(.TCK_HALF(TCK_HALF), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .TRST_n    (TRST_n),
    .cmd_if    (ifc),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .tap_state (tap_state)
  );

  assign TDO = tdo_force ? 1'b1 : TDI;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic tms);
    case (s)
      4'd0:    return tms ? 4'd0  : 4'd1;
      4'd1:    return tms ? 4'd2  : 4'd1;
      4'd2:    return tms ? 4'd9  : 4'd3;
      4'd3:    return tms ? 4'd5  : 4'd4;
      4'd4:    return tms ? 4'd5  : 4'd4;
      4'd5:    return tms ? 4'd8  : 4'd6;
      4'd6:    return tms ? 4'd7  : 4'd6;
      4'd7:    return tms ? 4'd8  : 4'd4;
      4'd8:    return tms ? 4'd2  : 4'd1;
      4'd9:    return tms ? 4'd0  : 4'd10;
      4'd10:   return tms ? 4'd12 : 4'd11;
      4'd11:   return tms ? 4'd12 : 4'd11;
      4'd12:   return tms ? 4'd15 : 4'd13;
      4'd13:   return tms ? 4'd14 : 4'd13;
      4'd14:   return tms ? 4'd15 : 4'd11;
      default: return tms ? 4'd2  : 4'd1;
    endcase
  endfunction

  // Target TAP model clocked by the DUT's TCK, logging TMS and state per rising edge.
  always @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      m_state <= 4'd0;
    end else begin
      m_state                   <= model_next(m_state, TMS);
      tms_log[rise_cnt[7:0]]    <= TMS;
      trace_log[rise_cnt[7:0]]  <= model_next(m_state, TMS);
      rise_cnt                  <= rise_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (TCK) high_cnt <= high_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                          output int rb, output int hb);
    int n;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("cmd_ready_timeout", 32'd1, 32'd0);
    rb = rise_cnt;
    hb = high_cnt;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_len   = len;
    ifc.cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'd3;
    ifc.cmd_len   = 6'd0;
    ifc.cmd_data  = 32'hFFFF_FFFF;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
    int n;
    n = 0;
    while (ifc.rsp_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("rsp_valid_timeout", 32'd1, 32'd0);
    lat = n;
    d   = ifc.rsp_data;
    e   = ifc.rsp_err;
  endtask

  task automatic take_rsp();
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    TRST_n = 1'b0;
    repeat (2) @(negedge clk);
    TRST_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [14];
    logic [31:0] d;
    logic        e;
    int          lat, rb, hb, flag;
    logic [5:0]  exp_tms;
    int          exp_tr [10];

    vecs[0]  = '{2'd2, 6'd8,  32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0, 14, 4'd1};
    vecs[1]  = '{2'd1, 6'd4,  32'h0000_000C, 1'b0, 32'h0000_000C, 1'b0, 10, 4'd1};
    vecs[2]  = '{2'd2, 6'd0,  32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 0,  4'd1};
    vecs[3]  = '{2'd2, 6'd32, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 37, 4'd1};
    vecs[4]  = '{2'd3, 6'd5,  32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 5,  4'd1};
    vecs[5]  = '{2'd1, 6'd1,  32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 7,  4'd1};
    vecs[6]  = '{2'd2, 6'd33, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 0,  4'd1};
    vecs[7]  = '{2'd3, 6'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 0,  4'd1};
    vecs[8]  = '{2'd1, 6'd0,  32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1, 0,  4'd1};
    vecs[9]  = '{2'd2, 6'd5,  32'h0000_0000, 1'b1, 32'h0000_001F, 1'b0, 10, 4'd1};
    vecs[10] = '{2'd0, 6'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 6,  4'd1};
    vecs[11] = '{2'd2, 6'd31, 32'h7FFF_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 36, 4'd1};
    vecs[12] = '{2'd2, 6'd1,  32'hFFFF_FFFE, 1'b0, 32'h0000_0000, 1'b0, 6,  4'd1};
    vecs[13] = '{2'd1, 6'd32, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 38, 4'd1};
    exp_tms = 6'b011111;
    exp_tr  = '{2, 9, 10, 11, 11, 11, 11, 12, 15, 1};

    n_vec = 0;
    n_bad = 0;
    TRST_n        = 1'b0;
    tdo_force     = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'd0;
    ifc.cmd_len   = 6'd0;
    ifc.cmd_data  = 32'h0;
    ifc.rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tck", {31'd0, TCK}, 32'd0);
    check("rst_tms", {31'd0, TMS}, 32'd1);
    check("rst_tdi", {31'd0, TDI}, 32'd0);
    check("rst_cmd_ready", {31'd0, ifc.cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    check("rst_rsp_data", ifc.rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, ifc.rsp_err}, 32'd0);
    check("rst_tap_state", {28'd0, tap_state}, 32'd0);
    TRST_n = 1'b1;
    check("ready_at_release", {31'd0, ifc.cmd_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_release", {31'd0, ifc.cmd_ready}, 32'd1);

    // Table: vector 0 starts from TLR and so carries the prefix bit
    for (int i = 0; i < 14; i++) begin
      tdo_force = vecs[i].tdo1;
      send_cmd(vecs[i].op, vecs[i].len, vecs[i].data, rb, hb);
      wait_rsp(d, e, lat);
      tdo_force = 1'b0;
      check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("v%0d_tcks", i), rise_cnt - rb, vecs[i].exp_tcks);
      check($sformatf("v%0d_tck_high_clks", i), high_cnt - hb, TCK_HALF * vecs[i].exp_tcks);
      check($sformatf("v%0d_tap_state", i), {28'd0, tap_state}, {28'd0, vecs[i].exp_state});
      check($sformatf("v%0d_model_state", i), {28'd0, m_state}, {28'd0, vecs[i].exp_state});
      if (vecs[i].exp_err) check($sformatf("v%0d_err_latency", i), lat, 32'd1);
      take_rsp();
      check($sformatf("v%0d_ready_after_rsp", i), {31'd0, ifc.cmd_ready}, 32'd1);
    end

    // RESET command straight after a hardware reset
    pulse_reset();
    send_cmd(2'd0, 6'd0, 32'h0, rb, hb);
    wait_rsp(d, e, lat);
    check("reset_tcks", rise_cnt - rb, 32'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("reset_tms_%0d", k), {31'd0, tms_log[8'(rb + k)]}, {31'd0, exp_tms[k]});
    end
    check("reset_tap_state", {28'd0, tap_state}, 32'd1);
    check("reset_model_state", {28'd0, m_state}, 32'd1);
    take_rsp();

    // IR scan state trace from RTI
    send_cmd(2'd1, 6'd4, 32'h0000_000C, rb, hb);
    wait_rsp(d, e, lat);
    check("ir_data", d, 32'h0000_000C);
    check("ir_high_clks", high_cnt - hb, 32'd20);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("ir_trace_%0d", k), {28'd0, trace_log[8'(rb + k)]}, exp_tr[k]);
    end
    take_rsp();

    // TRST during shift bit 3 of a 32-bit DR scan
    send_cmd(2'd2, 6'd32, 32'hF0F0_F0F0, rb, hb);
    flag = 0;
    while ((rise_cnt - rb) < 6 && flag < 500) begin
      @(negedge clk);
      flag++;
    end
    check("trst_reach_shift", {28'd0, m_state}, 32'd4);
    #2;
    TRST_n = 1'b0;
    #1;
    check("trst_tck", {31'd0, TCK}, 32'd0);
    check("trst_tms", {31'd0, TMS}, 32'd1);
    check("trst_tap_state", {28'd0, tap_state}, 32'd0);
    check("trst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    TRST_n = 1'b1;
    flag = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b0 || TCK !== 1'b0) flag = 1;
    end
    check("trst_quiet_after", flag, 32'd0);
    check("trst_ready_after", {31'd0, ifc.cmd_ready}, 32'd1);

    // IDLE from TLR gets the extra TMS=0 bit
    send_cmd(2'd3, 6'd3, 32'h0, rb, hb);
    wait_rsp(d, e, lat);
    check("idle_prefix_tcks", rise_cnt - rb, 32'd4);
    check("idle_prefix_tap", {28'd0, tap_state}, 32'd1);
    take_rsp();

    // Response held under back-pressure
    send_cmd(2'd2, 6'd8, 32'h0000_003C, rb, hb);
    wait_rsp(d, e, lat);
    rb = rise_cnt;
    hb = high_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", k),
            {ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_data[29:0]},
            {1'b1, 1'b0, 30'h0000_003C});
    end
    check("hold_no_tck", (rise_cnt - rb) + (high_cnt - hb), 32'd0);
    take_rsp();
    check("hold_release_ready", {30'd0, ifc.cmd_ready, ifc.rsp_valid}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
